servo_ramp: RTL
===============

SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 SHALL have parameter FRAME_CLOCKS, default 240000, meaning servo frame period in raw_clk cycles (20 ms at 12 MHz).
REQ-002 SHALL have parameter MIN_PULSE, default 12000, meaning lowest legal pulse width in clocks (1.0 ms).
REQ-003 SHALL have parameter MAX_PULSE, default 24000, meaning highest legal pulse width in clocks (2.0 ms).
REQ-004 SHALL have parameter CENTER_PULSE, default 18000, meaning reset pulse width in clocks (1.5 ms).
REQ-005 SHALL have port raw_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port bus_address, input, 3, register select.
REQ-008 SHALL have port bus_write_data, input, 16, write data.
REQ-009 SHALL have port bus_write_enable, input, 1, single-cycle write strobe.
REQ-010 SHALL have port bus_read_data, output, 16, registered readback.
REQ-011 SHALL have ports servo_value_0..servo_value_3, output, 16 each, current pulse widths driven to the downstream PWM generator.
REQ-012 SHALL have port frame_tick, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-013 Register map SHALL be: 0-3 target of servo 0-3 (R/W); 4 step size (R/W); 5 control, bit0 ramp_enable (R/W, other bits read 0); 6 status, bits[3:0] settled[i] = (servo_value_i == target_i) (RO); 7 reads 0.
REQ-014 Writes to addresses 6 and 7 SHALL be ignored.
REQ-015 A target write SHALL store the value clamped to [MIN_PULSE, MAX_PULSE], with unsigned comparison.
REQ-016 bus_read_data SHALL reflect the register at bus_address sampled one cycle earlier (1-cycle read latency, reads every cycle, no strobe).
REQ-017 A frame counter SHALL count 0..FRAME_CLOCKS-1 and wrap; frame_tick SHALL be 1 exactly in the cycle the counter equals FRAME_CLOCKS-1.
REQ-018 With ramp_enable=1, on a frame_tick cycle each servo_value_i SHALL move toward target_i by min(step, |target_i - servo_value_i|), updated on the following edge.
REQ-019 Difference arithmetic SHALL use 17 bits; outputs SHALL never overshoot the target nor leave [MIN_PULSE, MAX_PULSE].
REQ-020 With ramp_enable=1 and step=0, outputs SHALL hold.
REQ-021 With ramp_enable=0, each servo_value_i SHALL equal target_i one cycle after any target change, independent of frame_tick.
REQ-022 A write coinciding with frame_tick SHALL not affect that tick's update, which uses the pre-write target and step; the new value applies from the next cycle on.
REQ-023 Clearing ramp_enable mid-ramp SHALL snap all outputs to their targets on the next edge.
REQ-024 All four channels SHALL update in the same cycle; no channel-to-channel skew.

Reset
REQ-025 On reset, targets and servo_value_0..3 SHALL be CENTER_PULSE; step SHALL be 120; ramp_enable SHALL be 0; frame counter SHALL be 0; frame_tick SHALL be 0; bus_read_data SHALL be 0.
REQ-026 Reset asserted mid-ramp or mid-write SHALL take priority over all other updates in that cycle.

Structure
REQ-027 Shared package servo_pkg SHALL hold the register address constants (REG_TARGET0..3, REG_STEP, REG_CONTROL, REG_STATUS) and the default pulse/frame constants.
REQ-028 Per-channel step/clamp logic SHALL be one sub-module servo_ramp_channel, instantiated four times; frame counter and register decode stay in the top.

Verification
REQ-029 Reset, then read addresses 0-6 -> 18000 x4, 120, 0, 0x000f.
REQ-030 ramp_enable=0, write target0=30000 -> servo_value_0=24000 after one cycle; read addr0 -> 24000; write target1=5000 -> 12000.
REQ-031 ramp_enable=1, step=1000, target2=20500 -> servo_value_2 becomes 19000, 20000, 20500 on three successive frame_ticks, then holds; settled[2] sets after the third.
REQ-032 Write target3=12000 on the exact frame_tick cycle with ramp on, step=120 -> no change at that tick; 17880 at the next tick.
REQ-033 Mid-ramp (servo0 at 19000 heading to 24000), write control=0 -> servo_value_0=24000 next cycle; assert reset mid-ramp -> all outputs 18000, frame counter 0.
REQ-034 Frame counter check: frame_tick pulses exactly every 240000 cycles, width 1 cycle.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants for the four-channel servo ramp: register map, pulse limits and frame timing.
package servo_pkg;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;

    localparam int unsigned DEF_FRAME_CLOCKS = 240000;
    localparam int unsigned DEF_MIN_PULSE    = 12000;
    localparam int unsigned DEF_MAX_PULSE    = 24000;
    localparam int unsigned DEF_CENTER_PULSE = 18000;
    localparam logic [DATA_W-1:0] DEF_STEP   = 16'd120;

    localparam logic [2:0] REG_TARGET0 = 3'd0;
    localparam logic [2:0] REG_TARGET1 = 3'd1;
    localparam logic [2:0] REG_TARGET2 = 3'd2;
    localparam logic [2:0] REG_TARGET3 = 3'd3;
    localparam logic [2:0] REG_STEP    = 3'd4;
    localparam logic [2:0] REG_CONTROL = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;

endpackage

// File: rtl/servo_ramp_channel.sv
// One servo channel: holds its clamped target and slews its output toward it once per frame.
module servo_ramp_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE    = DEF_MAX_PULSE,
    parameter int unsigned CENTER_PULSE = DEF_CENTER_PULSE
) (
    input  logic              raw_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] step,
    input  logic              ramp_en,
    input  logic              tick,
    output logic [DATA_W-1:0] target,
    output logic [DATA_W-1:0] value,
    output logic              settled
);

    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] value_q, value_d;

    function automatic logic [DATA_W-1:0] clamp_pulse(input logic [DATA_W-1:0] raw);
        if (raw < DATA_W'(MIN_PULSE)) begin
            clamp_pulse = DATA_W'(MIN_PULSE);
        end else if (raw > DATA_W'(MAX_PULSE)) begin
            clamp_pulse = DATA_W'(MAX_PULSE);
        end else begin
            clamp_pulse = raw;
        end
    endfunction

    // Lands exactly on the target when the remaining distance is within one step,
    // so the output can never overshoot or leave the legal pulse range.
    function automatic logic [DATA_W-1:0] ramp_toward(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] tgt,
        input logic [DATA_W-1:0] stp
    );
        logic signed [DATA_W:0] diff;
        logic        [DATA_W:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
        if ({1'b0, stp} >= mag) begin
            ramp_toward = tgt;
        end else if (diff[DATA_W]) begin
            ramp_toward = cur - stp;
        end else begin
            ramp_toward = cur + stp;
        end
    endfunction

    // Target and step are the registered (pre-write) values, so a write landing
    // on a tick edge only takes effect from the following cycle.
    always_comb begin
        target_d = target_q;
        value_d  = value_q;
        if (wr_en) begin
            target_d = clamp_pulse(wr_data);
        end
        if (!ramp_en) begin
            value_d = target_q;
        end else if (tick) begin
            value_d = ramp_toward(value_q, target_q, step);
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            target_q <= DATA_W'(CENTER_PULSE);
            value_q  <= DATA_W'(CENTER_PULSE);
        end else begin
            target_q <= target_d;
            value_q  <= value_d;
        end
    end

    assign target  = target_q;
    assign value   = value_q;
    assign settled = (value_q == target_q);

endmodule

// File: rtl/servo_ramp.sv
// Four-channel servo pulse-width ramp with a small register bus and a frame-rate update tick.
module servo_ramp
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CLOCKS = DEF_FRAME_CLOCKS,
    parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE    = DEF_MAX_PULSE,
    parameter int unsigned CENTER_PULSE = DEF_CENTER_PULSE
) (
    input  logic              raw_clk,
    input  logic              reset,
    input  logic [2:0]        bus_address,
    input  logic [15:0]       bus_write_data,
    input  logic              bus_write_enable,
    output logic [15:0]       bus_read_data,
    output logic [15:0]       servo_value_0,
    output logic [15:0]       servo_value_1,
    output logic [15:0]       servo_value_2,
    output logic [15:0]       servo_value_3,
    output logic              frame_tick
);

    localparam int CNT_W = (FRAME_CLOCKS > 1) ? $clog2(FRAME_CLOCKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLOCKS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic              ramp_en_q, ramp_en_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic [DATA_W-1:0] ch_target [NUM_CH];
    logic [DATA_W-1:0] ch_value  [NUM_CH];
    logic [NUM_CH-1:0] ch_settled;
    logic [NUM_CH-1:0] ch_we;

    assign frame_tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = frame_tick ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        step_d    = step_q;
        ramp_en_d = ramp_en_q;
        if (bus_write_enable) begin
            if (bus_address == REG_STEP) begin
                step_d = bus_write_data;
            end else if (bus_address == REG_CONTROL) begin
                ramp_en_d = bus_write_data[0];
            end
        end
    end

    always_comb begin
        rd_d = '0;
        case (bus_address)
            REG_TARGET0: rd_d = ch_target[0];
            REG_TARGET1: rd_d = ch_target[1];
            REG_TARGET2: rd_d = ch_target[2];
            REG_TARGET3: rd_d = ch_target[3];
            REG_STEP:    rd_d = step_q;
            REG_CONTROL: rd_d = {15'd0, ramp_en_q};
            REG_STATUS:  rd_d = {12'd0, ch_settled};
            default:     rd_d = '0;
        endcase
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            cnt_q     <= '0;
            step_q    <= DEF_STEP;
            ramp_en_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            ramp_en_q <= ramp_en_d;
            rd_q      <= rd_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = bus_write_enable && (bus_address == 3'(i));

        servo_ramp_channel #(
            .MIN_PULSE    (MIN_PULSE),
            .MAX_PULSE    (MAX_PULSE),
            .CENTER_PULSE (CENTER_PULSE)
        ) u_ch (
            .raw_clk (raw_clk),
            .reset   (reset),
            .wr_en   (ch_we[i]),
            .wr_data (bus_write_data),
            .step    (step_q),
            .ramp_en (ramp_en_q),
            .tick    (frame_tick),
            .target  (ch_target[i]),
            .value   (ch_value[i]),
            .settled (ch_settled[i])
        );
    end

    assign bus_read_data = rd_q;
    assign servo_value_0 = ch_value[0];
    assign servo_value_1 = ch_value[1];
    assign servo_value_2 = ch_value[2];
    assign servo_value_3 = ch_value[3];

endmodule
